// File: rtl/go_ui_pkg.sv
// rtl/go_ui_pkg.sv - shared constants, place FSM states and one-hot helpers for the Go front panel
// Purpose: board geometry, button indices, place FSM state type and
//          one-hot cursor step / index conversion functions.
// Ports:   none (package).
package go_ui_pkg;

    localparam int BOARD_N    = 19;
    localparam int CENTER_IDX = 9;

    // Button slots in the debouncer array
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_PLACE = 4;

    typedef logic [BOARD_N-1:0] onehot_t;
    typedef logic [4:0]         idx_t;

    localparam onehot_t CENTER_ONEHOT = onehot_t'(1 << CENTER_IDX);

    typedef enum logic [1:0] {
        P_IDLE,
        P_HOLD,
        P_GAP
    } place_state_t;

    // Move the set bit towards bit 0; at bit 0 either rotate to the top or stay.
    function automatic onehot_t onehot_step_dn(input onehot_t v, input logic wrap);
        onehot_t r;
        r = v >> 1;
        if (v[0]) begin
            r = wrap ? {1'b1, {(BOARD_N-1){1'b0}}} : v;
        end
        return r;
    endfunction

    // Move the set bit towards the top; at the top either rotate to bit 0 or stay.
    function automatic onehot_t onehot_step_up(input onehot_t v, input logic wrap);
        onehot_t r;
        r = v << 1;
        if (v[BOARD_N-1]) begin
            r = wrap ? {{(BOARD_N-1){1'b0}}, 1'b1} : v;
        end
        return r;
    endfunction

    function automatic idx_t onehot_to_idx(input onehot_t v);
        idx_t idx;
        idx = '0;
        for (int i = 0; i < BOARD_N; i++) begin
            if (v[i]) idx = idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/go_cursor_ctrl_if.sv
// rtl/go_cursor_ctrl_if.sv - button inputs and cursor/place outputs of the Go front panel
// Purpose: bundles the five raw buttons and the cursor/place outputs.
// Signals: btn_up/btn_down/btn_left/btn_right/btn_place (raw, active-high),
//          x/y (one-hot 19), x_idx/y_idx (binary 5), place (level).
// Modports: master = button source / output consumer, slave = cursor controller.
interface go_cursor_ctrl_if;
    import go_ui_pkg::*;

    logic    btn_up;
    logic    btn_down;
    logic    btn_left;
    logic    btn_right;
    logic    btn_place;
    onehot_t x;
    onehot_t y;
    idx_t    x_idx;
    idx_t    y_idx;
    logic    place;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_place,
        input  x, y, x_idx, y_idx, place
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_place,
        output x, y, x_idx, y_idx, place
    );

endinterface

// File: rtl/go_btn_debounce.sv
// rtl/go_btn_debounce.sv - 2-flop synchroniser plus counting debouncer with rising-edge flag
// Purpose: accepts a level change only after DEBOUNCE_CYCLES consecutive
//          differing synchronised samples.
// Ports:   clk, rst_n (sync, active-low), i_btn (raw async),
//          o_level (debounced level), o_rise (one-cycle pulse on 0->1).
module go_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_rise;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                // This sample is the DEBOUNCE_CYCLES-th differing one: accept it.
                r_level <= r_sync2;
                r_rise  <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

// File: rtl/go_cursor_ctrl.sv
// rtl/go_cursor_ctrl.sv - Go board cursor controller: debounced buttons, auto-repeat, place pulse
// Purpose: moves a one-hot x/y cursor from debounced direction buttons with
//          auto-repeat and emits a fixed-width place pulse with the cursor frozen.
// Ports:   clk, rst_n (sync, active-low), bus (go_cursor_ctrl_if.slave).
module go_cursor_ctrl
    import go_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_RATE     = 16,
    parameter int PLACE_HOLD      = 4,
    parameter int WRAP            = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    go_cursor_ctrl_if.slave bus
);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int PW   = $clog2(PLACE_HOLD + 1);
    localparam logic [RW-1:0] R_DELAY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] R_RATE  = RW'(REPEAT_RATE);
    localparam logic [RW-1:0] R_MAX   = RW'(RMAX);
    localparam logic [PW-1:0] P_LAST  = PW'(PLACE_HOLD - 1);
    localparam logic          WRAP_EN = (WRAP != 0);

    logic [4:0] w_raw;
    logic [4:0] w_level;
    logic [4:0] w_rise;
    logic [3:0] w_step;

    assign w_raw = {bus.btn_place, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

    for (genvar b = 0; b < 5; b++) begin : g_btn
        go_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_btn   (w_raw[b]),
            .o_level (w_level[b]),
            .o_rise  (w_rise[b])
        );
    end

    // Per-direction repeat: r_cnt counts cycles since the last step; the first
    // repeat waits REPEAT_DELAY, later ones REPEAT_RATE (r_on = first repeat done).
    for (genvar d = 0; d < 4; d++) begin : g_rep
        logic [RW-1:0] r_cnt;
        logic          r_on;

        assign w_step[d] = w_rise[d] |
                           (w_level[d] & (r_cnt == (r_on ? R_RATE : R_DELAY)));

        always_ff @(posedge clk) begin
            if (!rst_n || !w_level[d]) begin
                r_cnt <= '0;
                r_on  <= 1'b0;
            end else if (w_rise[d]) begin
                r_cnt <= RW'(1);
                r_on  <= 1'b0;
            end else if (w_step[d]) begin
                r_cnt <= RW'(1);
                r_on  <= 1'b1;
            end else if (r_cnt != R_MAX) begin
                r_cnt <= r_cnt + RW'(1);
            end
        end
    end

    // Place FSM
    place_state_t  r_pstate, w_pstate_nxt;
    logic [PW-1:0] r_pcnt, w_pcnt_nxt;
    logic          r_place;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pstate <= P_IDLE;
            r_pcnt   <= '0;
            r_place  <= 1'b0;
        end else begin
            r_pstate <= w_pstate_nxt;
            r_pcnt   <= w_pcnt_nxt;
            r_place  <= (w_pstate_nxt == P_HOLD);
        end
    end

    always_comb begin
        w_pstate_nxt = r_pstate;
        w_pcnt_nxt   = r_pcnt;
        case (r_pstate)
            P_IDLE: begin
                if (w_rise[BTN_PLACE]) begin
                    w_pstate_nxt = P_HOLD;
                    w_pcnt_nxt   = '0;
                end
            end
            P_HOLD: begin
                if (r_pcnt == P_LAST) begin
                    w_pstate_nxt = P_GAP;
                    w_pcnt_nxt   = '0;
                end else begin
                    w_pcnt_nxt = r_pcnt + PW'(1);
                end
            end
            P_GAP: begin
                if (r_pcnt == P_LAST) begin
                    w_pstate_nxt = P_IDLE;
                    w_pcnt_nxt   = '0;
                end else begin
                    w_pcnt_nxt = r_pcnt + PW'(1);
                end
            end
            default: begin
                w_pstate_nxt = P_IDLE;
                w_pcnt_nxt   = '0;
            end
        endcase
    end

    // Cursor: steps only land while idle so the coordinates hold across a pulse;
    // opposing steps on one axis cancel.
    onehot_t r_x, r_y, w_x_nxt, w_y_nxt;
    idx_t    r_x_idx, r_y_idx;

    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        if (r_pstate == P_IDLE) begin
            if (w_step[BTN_LEFT] && !w_step[BTN_RIGHT]) begin
                w_x_nxt = onehot_step_dn(r_x, WRAP_EN);
            end else if (w_step[BTN_RIGHT] && !w_step[BTN_LEFT]) begin
                w_x_nxt = onehot_step_up(r_x, WRAP_EN);
            end
            if (w_step[BTN_UP] && !w_step[BTN_DOWN]) begin
                w_y_nxt = onehot_step_dn(r_y, WRAP_EN);
            end else if (w_step[BTN_DOWN] && !w_step[BTN_UP]) begin
                w_y_nxt = onehot_step_up(r_y, WRAP_EN);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x     <= CENTER_ONEHOT;
            r_y     <= CENTER_ONEHOT;
            r_x_idx <= idx_t'(CENTER_IDX);
            r_y_idx <= idx_t'(CENTER_IDX);
        end else begin
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_x_idx <= onehot_to_idx(w_x_nxt);
            r_y_idx <= onehot_to_idx(w_y_nxt);
        end
    end

    assign bus.x     = r_x;
    assign bus.y     = r_y;
    assign bus.x_idx = r_x_idx;
    assign bus.y_idx = r_y_idx;
    assign bus.place = r_place;

endmodule
